alu_top: RTL and testbench

//  Pipelined, registered 8-bit ALU: arithmetic (mode=1) or logical (mode=0) command on opa/opb.

---
 rtl/alu_top.sv | 178 +++++++++++++++++
 tb/tb_alu_top.sv | 91 +++++++++
 2 files changed

// File: rtl/alu_top.sv
// Registered 8-bit ALU: input stage, compute stage, optional multiply stage, output register.
// Arithmetic (mode=1) and logical (mode=0) commands with carry, overflow, compare and error flags.
module alu_top #(
  parameter int OP_WIDTH  = 8,
  parameter int CMD_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [1:0]            inp_valid,
  input  logic                  mode,
  input  logic [CMD_WIDTH-1:0]  cmd,
  input  logic                  cin,
  input  logic [OP_WIDTH-1:0]   opa,
  input  logic [OP_WIDTH-1:0]   opb,
  output logic [2*OP_WIDTH-1:0] res,
  output logic                  cout,
  output logic                  oflow,
  output logic                  g,
  output logic                  l,
  output logic                  e,
  output logic                  err
);
  localparam int W = OP_WIDTH;

  // stage 1: operand capture and error classification
  logic                 a_only, b_only, two_op, bad_cmd, hard_err_next, rot_err_next;
  logic [W-1:0]         s1_a_reg, s1_b_reg;
  logic                 s1_cin_reg, s1_mode_reg, s1_herr_reg, s1_rerr_reg;
  logic [CMD_WIDTH-1:0] s1_cmd_reg;

  always_comb begin
    a_only  = 1'b0;
    b_only  = 1'b0;
    two_op  = 1'b0;
    bad_cmd = 1'b0;
    if (mode) begin
      if (cmd > CMD_WIDTH'(12))                            bad_cmd = 1'b1;
      else if (cmd == CMD_WIDTH'(4) || cmd == CMD_WIDTH'(5)) a_only = 1'b1;
      else if (cmd == CMD_WIDTH'(6) || cmd == CMD_WIDTH'(7)) b_only = 1'b1;
      else                                                  two_op = 1'b1;
    end else begin
      if (cmd > CMD_WIDTH'(13))                              bad_cmd = 1'b1;
      else if (cmd == CMD_WIDTH'(6) || cmd == CMD_WIDTH'(8) || cmd == CMD_WIDTH'(9))   a_only = 1'b1;
      else if (cmd == CMD_WIDTH'(7) || cmd == CMD_WIDTH'(10) || cmd == CMD_WIDTH'(11)) b_only = 1'b1;
      else                                                    two_op = 1'b1;
    end
    hard_err_next = bad_cmd | (a_only & ~inp_valid[0]) | (b_only & ~inp_valid[1]) |
                    (two_op & (inp_valid != 2'b11));
    rot_err_next  = ~mode & (cmd == CMD_WIDTH'(12) || cmd == CMD_WIDTH'(13)) & (opb[W-1:3] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a_reg <= '0; s1_b_reg <= '0; s1_cin_reg <= 1'b0; s1_mode_reg <= 1'b0;
      s1_cmd_reg <= '0; s1_herr_reg <= 1'b0; s1_rerr_reg <= 1'b0;
    end else if (ce) begin
      s1_a_reg <= opa; s1_b_reg <= opb; s1_cin_reg <= cin; s1_mode_reg <= mode;
      s1_cmd_reg <= cmd; s1_herr_reg <= hard_err_next; s1_rerr_reg <= rot_err_next;
    end
  end

  // stage 2: all non-multiply results, plus prepared multiplier operands
  logic [W:0]     ax, bx, sax, sbx, v9;
  logic [2*W-1:0] dbl_rol, dbl_ror, res_next;
  logic [W-1:0]   lv;
  logic           cout_next, oflow_next, g_next, l_next, e_next, mul_next;
  logic [W:0]     ma_next, mb_next;

  always_comb begin
    ax  = {1'b0, s1_a_reg};
    bx  = {1'b0, s1_b_reg};
    sax = {s1_a_reg[W-1], s1_a_reg};
    sbx = {s1_b_reg[W-1], s1_b_reg};
    dbl_rol = {s1_a_reg, s1_a_reg} << s1_b_reg[2:0];
    dbl_ror = {s1_a_reg, s1_a_reg} >> s1_b_reg[2:0];
    v9 = '0; lv = '0;
    cout_next = 1'b0; oflow_next = 1'b0; g_next = 1'b0; l_next = 1'b0; e_next = 1'b0;
    mul_next = 1'b0; ma_next = '0; mb_next = '0;
    res_next = '0;
    if (!s1_herr_reg) begin
      if (s1_mode_reg) begin
        case (s1_cmd_reg)
          CMD_WIDTH'(0):  begin v9 = ax + bx;                    cout_next = v9[W]; end
          CMD_WIDTH'(1):  begin v9 = ax - bx;                    oflow_next = s1_a_reg < s1_b_reg; end
          CMD_WIDTH'(2):  begin v9 = ax + bx + (W+1)'(s1_cin_reg); cout_next = v9[W]; end
          CMD_WIDTH'(3):  begin
            v9 = ax - bx - (W+1)'(s1_cin_reg);
            oflow_next = (s1_a_reg < s1_b_reg) || (s1_a_reg == s1_b_reg && s1_cin_reg);
          end
          CMD_WIDTH'(4):  begin v9 = ax + 1'b1; cout_next = v9[W]; end
          CMD_WIDTH'(5):  begin v9 = ax - 1'b1; oflow_next = (s1_a_reg == '0); end
          CMD_WIDTH'(6):  begin v9 = bx + 1'b1; cout_next = v9[W]; end
          CMD_WIDTH'(7):  begin v9 = bx - 1'b1; oflow_next = (s1_b_reg == '0); end
          CMD_WIDTH'(8):  begin
            g_next = s1_a_reg > s1_b_reg;
            l_next = s1_a_reg < s1_b_reg;
            e_next = s1_a_reg == s1_b_reg;
          end
          CMD_WIDTH'(9):  begin mul_next = 1'b1; ma_next = ax + 1'b1; mb_next = bx + 1'b1; end
          CMD_WIDTH'(10): begin mul_next = 1'b1; ma_next = {s1_a_reg, 1'b0}; mb_next = bx; end
          CMD_WIDTH'(11), CMD_WIDTH'(12): begin
            v9 = (s1_cmd_reg == CMD_WIDTH'(11)) ? sax + sbx : sax - sbx;
            // overflow: result sign disagrees with A where the effective operand signs match
            oflow_next = (s1_cmd_reg == CMD_WIDTH'(11))
                       ? (s1_a_reg[W-1] == s1_b_reg[W-1]) && (v9[W-1] != s1_a_reg[W-1])
                       : (s1_a_reg[W-1] != s1_b_reg[W-1]) && (v9[W-1] != s1_a_reg[W-1]);
            g_next = $signed(s1_a_reg) > $signed(s1_b_reg);
            l_next = $signed(s1_a_reg) < $signed(s1_b_reg);
            e_next = s1_a_reg == s1_b_reg;
          end
          default: v9 = '0;
        endcase
        res_next = (2*W)'(v9);
      end else begin
        case (s1_cmd_reg)
          CMD_WIDTH'(0):  lv = s1_a_reg & s1_b_reg;
          CMD_WIDTH'(1):  lv = ~(s1_a_reg & s1_b_reg);
          CMD_WIDTH'(2):  lv = s1_a_reg | s1_b_reg;
          CMD_WIDTH'(3):  lv = ~(s1_a_reg | s1_b_reg);
          CMD_WIDTH'(4):  lv = s1_a_reg ^ s1_b_reg;
          CMD_WIDTH'(5):  lv = ~(s1_a_reg ^ s1_b_reg);
          CMD_WIDTH'(6):  lv = ~s1_a_reg;
          CMD_WIDTH'(7):  lv = ~s1_b_reg;
          CMD_WIDTH'(8):  lv = s1_a_reg >> 1;
          CMD_WIDTH'(9):  lv = s1_a_reg << 1;
          CMD_WIDTH'(10): lv = s1_b_reg >> 1;
          CMD_WIDTH'(11): lv = s1_b_reg << 1;
          CMD_WIDTH'(12): lv = dbl_rol[2*W-1:W];
          CMD_WIDTH'(13): lv = dbl_ror[W-1:0];
          default:        lv = '0;
        endcase
        res_next = (2*W)'(lv);
      end
    end
  end

  logic [2*W-1:0] s2_res_reg;
  logic           s2_cout_reg, s2_oflow_reg, s2_g_reg, s2_l_reg, s2_e_reg, s2_err_reg, s2_mul_reg;
  logic [W:0]     s2_ma_reg, s2_mb_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_res_reg <= '0; s2_cout_reg <= 1'b0; s2_oflow_reg <= 1'b0; s2_g_reg <= 1'b0;
      s2_l_reg <= 1'b0; s2_e_reg <= 1'b0; s2_err_reg <= 1'b0; s2_mul_reg <= 1'b0;
      s2_ma_reg <= '0; s2_mb_reg <= '0;
    end else if (ce) begin
      s2_res_reg <= res_next; s2_cout_reg <= cout_next; s2_oflow_reg <= oflow_next;
      s2_g_reg <= g_next; s2_l_reg <= l_next; s2_e_reg <= e_next;
      s2_err_reg <= s1_herr_reg | s1_rerr_reg; s2_mul_reg <= mul_next;
      s2_ma_reg <= ma_next; s2_mb_reg <= mb_next;
    end
  end

  // stage 3: multiplier; the output register only takes it once a multiply has reached here
  logic [2*W+1:0] prod_full;
  logic [2*W-1:0] s3_prod_reg;
  logic           s3_mul_reg;

  assign prod_full = {{(W+1){1'b0}}, s2_ma_reg} * {{(W+1){1'b0}}, s2_mb_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_prod_reg <= '0; s3_mul_reg <= 1'b0;
      res <= '0; cout <= 1'b0; oflow <= 1'b0; g <= 1'b0; l <= 1'b0; e <= 1'b0; err <= 1'b0;
    end else if (ce) begin
      s3_prod_reg <= prod_full[2*W-1:0];
      s3_mul_reg  <= s2_mul_reg;
      if (!s2_mul_reg) begin
        res <= s2_res_reg; cout <= s2_cout_reg; oflow <= s2_oflow_reg;
        g <= s2_g_reg; l <= s2_l_reg; e <= s2_e_reg; err <= s2_err_reg;
      end else if (s3_mul_reg) begin
        res <= s3_prod_reg; cout <= 1'b0; oflow <= 1'b0;
        g <= 1'b0; l <= 1'b0; e <= 1'b0; err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_top.sv
// Directed-vector bench for alu_top; expected values are hand-computed constants.
module tb_alu_top;
  logic        clk = 1'b0;
  logic        rst, ce, mode, cin;
  logic [1:0]  inp_valid;
  logic [3:0]  cmd;
  logic [7:0]  opa, opb;
  logic [15:0] res;
  logic        cout, oflow, g, l, e, err;
  logic [5:0]  flags;
  int          n_checks = 0;
  int          n_fail   = 0;

  alu_top #(.OP_WIDTH(8), .CMD_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .ce(ce), .inp_valid(inp_valid), .mode(mode), .cmd(cmd),
    .cin(cin), .opa(opa), .opb(opb), .res(res), .cout(cout), .oflow(oflow),
    .g(g), .l(l), .e(e), .err(err)
  );

  always #5 clk = ~clk;

  // flag order: {err, g, l, e, oflow, cout}
  assign flags = {err, g, l, e, oflow, cout};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else
      $display("ok   %s: 0x%0h", tag, got);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input logic m, input logic [3:0] c,
                         input logic [1:0] v, input logic ci, input logic [7:0] a,
                         input logic [7:0] b, input int edges,
                         input logic [15:0] exp_res, input logic [5:0] exp_flags);
    mode = m; cmd = c; inp_valid = v; cin = ci; opa = a; opb = b;
    repeat (edges) tick();
    check({tag, " res"}, 32'(res), 32'(exp_res));
    check({tag, " flags"}, 32'(flags), 32'(exp_flags));
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; mode = 1'b0; cin = 1'b0; inp_valid = 2'b00;
    cmd = 4'd0; opa = 8'd0; opb = 8'd0;
    repeat (2) tick();
    check("reset res", 32'(res), 32'h0);
    check("reset flags", 32'(flags), 32'h0);
    rst = 1'b0;

    //       tag          mode cmd    valid  cin   opa     opb    edges res       flags
    run_vec("add",        1, 4'd0,  2'b11, 0, 8'd255, 8'd1,   3, 16'h0100, 6'b000001);
    run_vec("sub",        1, 4'd1,  2'b11, 0, 8'd1,   8'd2,   3, 16'h01FF, 6'b000010);
    run_vec("sub_cin",    1, 4'd3,  2'b11, 1, 8'd20,  8'd20,  3, 16'h01FF, 6'b000010);
    run_vec("cmp",        1, 4'd8,  2'b11, 0, 8'd7,   8'd20,  3, 16'h0000, 6'b001000);
    run_vec("add_sign",   1, 4'd11, 2'b11, 0, 8'd127, 8'd10,  3, 16'h0089, 6'b010010);
    run_vec("sub_sign",   1, 4'd12, 2'b11, 0, 8'h80,  8'd5,   3, 16'h017B, 6'b001010);
    run_vec("add_sign_eq",1, 4'd11, 2'b11, 0, 8'hFF,  8'hFF,  3, 16'h01FE, 6'b000100);
    run_vec("inc_mul",    1, 4'd9,  2'b11, 0, 8'd8,   8'd2,   4, 16'd27,   6'b000000);
    run_vec("inc_mul_max",1, 4'd9,  2'b11, 0, 8'd254, 8'd254, 4, 16'd65025,6'b000000);
    run_vec("shl_mul",    1, 4'd10, 2'b11, 0, 8'h80,  8'd3,   4, 16'h0300, 6'b000000);
    run_vec("dec_a_zero", 1, 4'd5,  2'b01, 0, 8'd0,   8'd9,   3, 16'h01FF, 6'b000010);
    run_vec("xnor",       0, 4'd5,  2'b11, 0, 8'hF0,  8'h3C,  3, 16'h0033, 6'b000000);
    run_vec("not_b_noB",  0, 4'd7,  2'b01, 0, 8'h12,  8'h34,  3, 16'h0000, 6'b100000);
    run_vec("rol",        0, 4'd12, 2'b11, 0, 8'h81,  8'd1,   3, 16'h0003, 6'b000000);
    run_vec("bad_cmd",    1, 4'd15, 2'b11, 0, 8'd3,   8'd4,   3, 16'h0000, 6'b100000);
    run_vec("add_noA",    1, 4'd0,  2'b10, 0, 8'd3,   8'd4,   3, 16'h0000, 6'b100000);
    run_vec("ror_err",    0, 4'd13, 2'b11, 0, 8'h03,  8'hF1,  3, 16'h0081, 6'b100000);

    // frozen pipeline: new operands must not reach the outputs
    ce = 1'b0;
    run_vec("ce_hold",    1, 4'd0,  2'b11, 0, 8'd1,   8'd1,   4, 16'h0081, 6'b100000);

    // reset wins over a deasserted clock enable
    rst = 1'b1;
    tick();
    check("rst_no_ce res", 32'(res), 32'h0);
    check("rst_no_ce flags", 32'(flags), 32'h0);
    rst = 1'b0; ce = 1'b1;
    run_vec("after_rst",  1, 4'd0,  2'b11, 1, 8'd1,   8'd1,   3, 16'h0002, 6'b000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
